// File: rtl/dds_rsp_pkg.sv
// dds_rsp_pkg: shared types and constants for the DDS port responder.
package dds_rsp_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W = 8;
    localparam int WORD_W = BYTES_PER_WORD * BYTE_W;
    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    // Byte 0 of a bus word is the most significant byte.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w, input logic [CNT_W-1:0] c);
        return BYTE_W'(w >> (BYTE_W * (BYTES_PER_WORD - 1 - int'(c))));
    endfunction
endpackage

// File: rtl/dds_rsp_sync.sv
// dds_rsp_sync: STAGES-deep synchronizer with registered level and rise/fall outputs.
module dds_rsp_sync #(
    parameter int STAGES = 2,
    parameter int W = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         Cclk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);
    logic [STAGES-1:0][W-1:0] sr;

    // q lags the last sync stage by one flop so level and edge pulses line up.
    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            sr   <= {STAGES{RST_VAL}};
            q    <= RST_VAL;
            rise <= '0;
            fall <= '0;
        end else begin
            sr   <= {sr[STAGES-2:0], d};
            q    <= sr[STAGES-1];
            rise <= sr[STAGES-1] & ~q;
            fall <= ~sr[STAGES-1] & q;
        end
    end
endmodule

// File: rtl/dds_port_responder.sv
// dds_port_responder: byte-serial DDS bus slave committing 32-bit frequency words on IOup.
// Optional read-back path enabled by defining DDS_RSP_READBACK_EN.
module dds_port_responder
    import dds_rsp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter logic [WORD_W-1:0] RESET_WORD = 32'h0000_0000
) (
    input  logic              Cclk,
    input  logic              rstn,
    input  logic              DDS_PCLK,
    input  logic              DDS_CSn,
    input  logic              DDS_RWn,
    input  logic              DDS_IOup,
    input  logic [BYTE_W-1:0] DDS_DataOut,
    output logic [BYTE_W-1:0] DDS_DataIn,
    input  logic [WORD_W-1:0] ReadWord,
    output logic [WORD_W-1:0] FreqWord,
    output logic              FreqValid,
    output logic              PendingValid,
    output logic              FrameErr,
    input  logic              FrameErrClr
);
    logic pclk_rise, csn, rwn, rwn_rise, rwn_fall, iou_rise;
    logic [BYTE_W-1:0] data;
    logic pclk_q_unused, pclk_fall_unused, csn_rise_unused, csn_fall_unused, iou_q_unused, iou_fall_unused;
    logic [BYTE_W-1:0] data_rise_unused, data_fall_unused;

    dds_rsp_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b0)) u_pclk (
        .Cclk(Cclk), .rstn(rstn), .d(DDS_PCLK), .q(pclk_q_unused), .rise(pclk_rise), .fall(pclk_fall_unused));
    dds_rsp_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b1)) u_csn (
        .Cclk(Cclk), .rstn(rstn), .d(DDS_CSn), .q(csn), .rise(csn_rise_unused), .fall(csn_fall_unused));
    dds_rsp_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b0)) u_rwn (
        .Cclk(Cclk), .rstn(rstn), .d(DDS_RWn), .q(rwn), .rise(rwn_rise), .fall(rwn_fall));
    dds_rsp_sync #(.STAGES(SYNC_STAGES), .W(1), .RST_VAL(1'b0)) u_iou (
        .Cclk(Cclk), .rstn(rstn), .d(DDS_IOup), .q(iou_q_unused), .rise(iou_rise), .fall(iou_fall_unused));
    dds_rsp_sync #(.STAGES(SYNC_STAGES), .W(BYTE_W), .RST_VAL('0)) u_data (
        .Cclk(Cclk), .rstn(rstn), .d(DDS_DataOut), .q(data), .rise(data_rise_unused), .fall(data_fall_unused));

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WORD_W-1:0] shift_r, pend_r, commit_word;
    logic commit_req;

    wire xfer = pclk_rise & ~csn;
    wire last = xfer & (cnt == CNT_W'(BYTES_PER_WORD - 1));
    // A 4th byte arriving with the IOup edge is a clean boundary, not a framing error.
    wire err = (iou_rise & (~PendingValid | ((cnt != '0) & ~last))) | ((rwn_rise | rwn_fall) & (state != IDLE));
    wire take = xfer & ~err;
    wire wr4 = take & ~rwn & last;
    wire commit = iou_rise & PendingValid;
    wire [WORD_W-1:0] shift_nxt = {shift_r[WORD_W-BYTE_W-1:0], data};

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        if (err) begin
            state_n = IDLE;
            cnt_n = '0;
        end else if (take) begin
            cnt_n = cnt + 1'b1;
            state_n = last ? IDLE : (state == IDLE) ? (rwn ? RD : WR) : state;
        end
    end

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            shift_r      <= '0;
            pend_r       <= RESET_WORD;
            commit_word  <= RESET_WORD;
            commit_req   <= 1'b0;
            FreqWord     <= RESET_WORD;
            FreqValid    <= 1'b0;
            PendingValid <= 1'b0;
            FrameErr     <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            if (take && !rwn) shift_r <= shift_nxt;
            if (wr4) pend_r <= shift_nxt;
            PendingValid <= wr4 | (PendingValid & ~commit);
            commit_req   <= commit;
            if (commit) commit_word <= pend_r;
            FreqValid    <= commit_req;
            if (commit_req) FreqWord <= commit_word;
            FrameErr     <= err | (FrameErr & ~FrameErrClr);
        end
    end

`ifdef DDS_RSP_READBACK_EN
    logic [WORD_W-1:0] shadow;
    logic [BYTE_W-1:0] rd_byte;
    wire rd_take = take & rwn;
    wire [WORD_W-1:0] rd_src = (state == IDLE) ? ReadWord : shadow;

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            shadow  <= '0;
            rd_byte <= '0;
        end else begin
            if (rd_take && state == IDLE) shadow <= ReadWord;
            if (rd_take) rd_byte <= word_byte(rd_src, cnt);
        end
    end

    assign DDS_DataIn = (~csn & rwn) ? rd_byte : '0;
`else
    logic [WORD_W-1:0] read_word_unused;
    assign read_word_unused = ReadWord;
    assign DDS_DataIn = '0;
`endif
endmodule

// File: tb/tb_dds_port_responder.sv
// tb_dds_port_responder: vector table plus corner sequences; FreqValid checked against a scoreboard.
module tb_dds_port_responder;
    localparam int SS = 2;
`ifdef DDS_RSP_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic Cclk = 1'b0, rstn = 1'b0, pclk = 1'b0, csn = 1'b1, rwn = 1'b0, iou = 1'b0, clr = 1'b0;
    logic [7:0] dout = '0;
    logic [7:0] din;
    logic [31:0] rword = '0;
    logic [31:0] freq;
    logic fv, pv, fe;

    dds_port_responder #(.SYNC_STAGES(SS), .RESET_WORD(32'h0000_0000)) dut (
        .Cclk(Cclk), .rstn(rstn), .DDS_PCLK(pclk), .DDS_CSn(csn), .DDS_RWn(rwn), .DDS_IOup(iou),
        .DDS_DataOut(dout), .DDS_DataIn(din), .ReadWord(rword), .FreqWord(freq), .FreqValid(fv),
        .PendingValid(pv), .FrameErr(fe), .FrameErrClr(clr));

    always #5 Cclk = ~Cclk;

    int tests = 0, fails = 0;
    int cyc = 0, t0 = 0;
    logic [31:0] exp_q[$];
    logic [7:0] rd_q[$];

    always @(posedge Cclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Cclk);
    endtask

    // Every FreqValid pulse must match a queued commit, with the fixed IOup-to-valid latency.
    always @(negedge Cclk) begin
        if (rstn && fv) begin
            if (exp_q.size() == 0) check("freqvalid_unexpected", {31'b0, fv}, 32'd0);
            else begin
                check("freqword_at_valid", freq, exp_q.pop_front());
                check("freqvalid_latency", cyc - t0, SS + 2);
            end
        end
    end

    task automatic xfer_byte(input logic [7:0] b);
        @(negedge Cclk) dout = b;
        if (rwn) rd_q.push_back(RB ? b : 8'h00);
        tick(2);
        pclk = 1'b1;
        tick(4);
        pclk = 1'b0;
        tick(4);
        if (rwn) check("read_byte", {24'b0, din}, {24'b0, rd_q.pop_front()});
    endtask

    task automatic send_word(input bit r, input logic [31:0] w, input int n, input bit split);
        @(negedge Cclk) rwn = r;
        if (r) rword = w;
        tick(4);
        csn = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) begin
            if (split && i == 2) begin
                csn = 1'b1;
                tick(4);
                csn = 1'b0;
                tick(4);
            end
            xfer_byte(w[31-8*i -: 8]);
        end
        csn = 1'b1;
        tick(4);
        if (r) check("datain_cs_high", {24'b0, din}, 32'd0);
    endtask

    task automatic pulse_iou(input bit expect_commit, input logic [31:0] w);
        int k;
        @(negedge Cclk);
        if (expect_commit) exp_q.push_back(w);
        t0 = cyc + 1;
        iou = 1'b1;
        @(negedge Cclk) iou = 1'b0;
        k = 0;
        while (k < 20 && exp_q.size() != 0) begin
            tick(1);
            k++;
        end
        check("freqvalid_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
        tick(4);
    endtask

    task automatic clear_err();
        @(negedge Cclk) clr = 1'b1;
        @(negedge Cclk) clr = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        bit          split;
        logic [31:0] word;
        bit          iou;
        logic [31:0] exp_freq;
        bit          exp_pv;
        bit          exp_fe;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{rd: 0, split: 1, word: 32'h1234_5678, iou: 1, exp_freq: 32'h1234_5678, exp_pv: 0, exp_fe: 0};
        vt[1] = '{rd: 1, split: 0, word: 32'hA5C3_0FF0, iou: 0, exp_freq: 32'h1234_5678, exp_pv: 0, exp_fe: 0};
        vt[2] = '{rd: 0, split: 0, word: 32'h0000_0001, iou: 0, exp_freq: 32'h1234_5678, exp_pv: 1, exp_fe: 0};
        vt[3] = '{rd: 0, split: 0, word: 32'h0000_0002, iou: 1, exp_freq: 32'h0000_0002, exp_pv: 0, exp_fe: 0};
        vt[4] = '{rd: 0, split: 1, word: 32'hCAFE_F00D, iou: 1, exp_freq: 32'hCAFE_F00D, exp_pv: 0, exp_fe: 0};

        tick(3);
        check("reset_freqword", freq, 32'h0);
        check("reset_freqvalid", {31'b0, fv}, 32'd0);
        check("reset_pending", {31'b0, pv}, 32'd0);
        check("reset_frameerr", {31'b0, fe}, 32'd0);
        check("reset_datain", {24'b0, din}, 32'd0);
        rstn = 1'b1;
        tick(4);

        foreach (vt[i]) begin
            send_word(vt[i].rd, vt[i].word, 4, vt[i].split);
            if (!vt[i].rd) check("pending_after_write", {31'b0, pv}, 32'd1);
            if (vt[i].iou) pulse_iou(1'b1, vt[i].word);
            check("vec_freqword", freq, vt[i].exp_freq);
            check("vec_pending", {31'b0, pv}, {31'b0, vt[i].exp_pv});
            check("vec_frameerr", {31'b0, fe}, {31'b0, vt[i].exp_fe});
        end

        // IOup after a partial word with nothing pending
        send_word(1'b0, 32'hFFEE_DDCC, 2, 1'b0);
        pulse_iou(1'b0, 32'h0);
        check("err_nopend_fe", {31'b0, fe}, 32'd1);
        check("err_nopend_freq", freq, 32'hCAFE_F00D);
        check("err_nopend_pv", {31'b0, pv}, 32'd0);
        clear_err();
        tick(1);
        check("clr_fe", {31'b0, fe}, 32'd0);
        send_word(1'b0, 32'h0BAD_F00D, 4, 1'b0);
        pulse_iou(1'b1, 32'h0BAD_F00D);
        check("after_err_freq", freq, 32'h0BAD_F00D);
        check("after_err_fe", {31'b0, fe}, 32'd0);

        // IOup with a partial word on top of a pending word: commit and flag
        send_word(1'b0, 32'h1111_2222, 4, 1'b0);
        send_word(1'b0, 32'h3333_4444, 2, 1'b0);
        pulse_iou(1'b1, 32'h1111_2222);
        check("partial_commit_freq", freq, 32'h1111_2222);
        check("partial_commit_fe", {31'b0, fe}, 32'd1);
        check("partial_commit_pv", {31'b0, pv}, 32'd0);
        clear_err();
        send_word(1'b0, 32'h5555_6666, 4, 1'b0);
        pulse_iou(1'b1, 32'h5555_6666);
        check("partial_discarded_freq", freq, 32'h5555_6666);

        // RWn change mid-word
        send_word(1'b0, 32'h7700_0000, 1, 1'b0);
        @(negedge Cclk) rwn = 1'b1;
        tick(6);
        check("rwn_change_fe", {31'b0, fe}, 32'd1);
        rwn = 1'b0;
        tick(6);
        clear_err();
        tick(6);
        check("rwn_idle_change_fe", {31'b0, fe}, 32'd0);

        // Reset after byte 3 of a word
        @(negedge Cclk) rwn = 1'b0;
        tick(4);
        csn = 1'b0;
        tick(4);
        xfer_byte(8'hDE);
        xfer_byte(8'hAD);
        xfer_byte(8'hBE);
        @(negedge Cclk) rstn = 1'b0;
        tick(2);
        check("midreset_freq", freq, 32'h0);
        check("midreset_pv", {31'b0, pv}, 32'd0);
        csn = 1'b1;
        rstn = 1'b1;
        tick(4);
        send_word(1'b0, 32'h0000_00AA, 4, 1'b0);
        pulse_iou(1'b1, 32'h0000_00AA);
        check("after_reset_freq", freq, 32'h0000_00AA);
        check("after_reset_fe", {31'b0, fe}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/dds_port_responder.md
DDS_PORT_RESPONDER -- requirements
Module: dds_port_responder

Interface
REQ-001 Reset rstn, asynchronous, active-low; clock Cclk.
REQ-002 SYNC_STAGES, 2, synchronizer depth on every bus input; legal range 2..3.
REQ-003 RESET_WORD, 32'h0000_0000, reset value of FreqWord and of the pending word.
REQ-004 Cclk  in  1  responder clock; at least 4x the bus PCLK rate.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 DDS_PCLK  in  1  bus byte clock; data is sampled on its rising edge.
REQ-007 DDS_CSn  in  1  bus chip select, active-low.
REQ-008 DDS_RWn  in  1  1 = read, 0 = write; constant for the duration of a word.
REQ-009 DDS_IOup  in  1  update strobe; one Cclk wide at the controller, so it is edge-detected.
REQ-010 DDS_DataOut  in  8  write byte from the controller.
REQ-011 DDS_DataIn  out  8  read byte driven back to the controller.
REQ-012 ReadWord  in  32  word returned on a bus read.
REQ-013 FreqWord  out  32  active (committed) frequency word.
REQ-014 FreqValid  out  1  one-Cclk pulse when FreqWord updates.
REQ-015 PendingValid  out  1  a complete 4-byte write word is waiting for DDS_IOup.
REQ-016 FrameErr  out  1  sticky; set on a framing violation.
REQ-017 FrameErrClr  in  1  synchronous clear of FrameErr.

Function
REQ-018 All bus inputs SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized signals.
REQ-019 Byte transfer: a PCLK rising edge while CSn is low; bytes are ordered MSB first; a 2-bit ByteCnt increments per transfer.
REQ-020 ByteCnt SHALL hold while CSn is high, so one word may span several CS windows.
REQ-021 FSM states are IDLE, WR and RD.
- IDLE->WR on the first transfer with RWn=0; IDLE->RD on the first transfer with RWn=1.
- WR/RD->IDLE when ByteCnt wraps 3->0.
REQ-022 WR: each transfer shifts DDS_DataOut into a 32-bit shift register; on the 4th byte the shift register SHALL be copied to the pending word and PendingValid set the same cycle.
REQ-023 A new 4th byte while PendingValid=1 SHALL overwrite the pending word; FrameErr is not set.
REQ-024 On a detected IOup rising edge with PendingValid=1:
- the pending word SHALL be copied to FreqWord the next Cclk;
- FreqValid pulses for that Cclk;
- PendingValid clears.
REQ-025 Latency: FreqValid SHALL occur exactly SYNC_STAGES+2 Cclk after the first Cclk edge that samples DDS_IOup high.
REQ-026 Framing errors set FrameErr, and the FSM SHALL return to IDLE with ByteCnt=0:
- an IOup edge with PendingValid=0;
- an IOup edge with ByteCnt!=0;
- an RWn change while in WR or RD.
REQ-027 IOup with ByteCnt!=0 and PendingValid=1 SHALL still commit the pending word and SHALL discard the partial word.
REQ-028 If IOup and a 4th-byte transfer coincide, the earlier pending word SHALL commit and the new word SHALL become pending.
REQ-029 FrameErrClr and a simultaneous new error: set wins.
REQ-030 RD: on the IDLE->RD transfer, ReadWord SHALL be latched into a read shadow register.
- DDS_DataIn = shadow byte[3-ByteCnt] while CSn is low and RWn=1; otherwise 8'h00.
- ByteCnt 0 presents bits [31:24]; the byte updates one Cclk after each transfer.
REQ-031 Read transfers SHALL NOT affect the pending word, FreqWord or FreqValid.

Reset
REQ-032 On reset:
- FreqWord and the pending word = RESET_WORD; shift register = 0;
- FreqValid, PendingValid and FrameErr = 0; DDS_DataIn = 8'h00;
- FSM = IDLE; ByteCnt = 0; synchronizer flops: CSn = 1, all others 0.
REQ-033 Reset mid-word SHALL discard the partial word; the next transfer after release starts at byte 0.

Configuration
REQ-034 Macro DDS_RSP_READBACK_EN.
- Defined: the RD path of REQ-030 is present.
- Undefined: no read shadow register; DDS_DataIn is tied to 8'h00; RD state still tracks ByteCnt so that framing stays correct.

Structure
REQ-035 Package dds_rsp_pkg holds:
- the FSM state typedef (IDLE/WR/RD);
- BYTES_PER_WORD = 4 and BYTE_W = 8;
- the ByteCnt width constant.
REQ-036 Sub-module dds_rsp_sync: a SYNC_STAGES synchronizer plus rise/fall detect, instanced per bus input.

Verification
REQ-037 Write 32'h1234_5678 over two CS windows (2 bytes each), then an IOup pulse -> FreqWord = 32'h1234_5678; FreqValid 1 cycle at SYNC_STAGES+2; PendingValid 1->0.
REQ-038 ReadWord = 32'hA5C3_0FF0, 4-byte read -> DDS_DataIn = A5, C3, 0F, F0 per transfer; FreqWord unchanged.
REQ-039 IOup after 2 write bytes with no pending word -> FrameErr = 1; FreqWord unchanged; next 4-byte write plus IOup commits correctly.
REQ-040 Two back-to-back writes, 32'h1 then 32'h2, then one IOup -> FreqWord = 32'h2 (overwrite); FrameErr = 0.
REQ-041 rstn asserted after byte 3 of 32'hDEAD_BEEF, then write 32'h0000_00AA plus IOup -> FreqWord = 32'h0000_00AA.
REQ-042 Build without DDS_RSP_READBACK_EN, 4-byte read -> DDS_DataIn = 00 throughout; write path per REQ-037 is unaffected.
